regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
 DATA_W  32  register data width
 ADDR_W  5  register address width (2^ADDR_W registers)
 ZERO_R0  1  when 1, writes to address 0 are acknowledged but never issued
REQ-002 Ports SHALL be, one per line:
 clk  in  1  single clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 clear  in  1  request re-zeroing of all registers
 a_valid  in  1  requester A (writeback, priority-equal) has a write
 a_ready  out  1  A write accepted this cycle
 a_addr  in  ADDR_W  A destination register
 a_data  in  DATA_W  A write data
 b_valid, b_ready, b_addr, b_data  as A, for requester B (load return)
 rf_we  out  1  register file write enable
 rf_waddr  out  ADDR_W  register file write address
 rf_wdata  out  DATA_W  register file write data
 init_busy  out  1  zeroing sequence in progress
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL own the single register-file write port and serialize writes from A, B and the internal zeroing sequencer.
REQ-005 State machine SHALL have states INIT and RUN; reset enters INIT.
REQ-006 In INIT, a 5-bit (ADDR_W) counter SHALL start at 0 and issue rf_we=1, rf_waddr=count, rf_wdata=0 on each cycle, incrementing by 1.
REQ-007 INIT SHALL transition to RUN on the cycle after address 2^ADDR_W-1 is issued; INIT therefore lasts exactly 2^ADDR_W cycles (32 by default).
REQ-008 init_busy SHALL be 1 exactly while in INIT; a_ready and b_ready SHALL be 0 in INIT.
REQ-009 In RUN, a handshake SHALL complete on a cycle where x_valid and x_ready are both 1; at most one handshake SHALL complete per cycle.
REQ-010 Readies SHALL be combinational from valids and state: only one requester valid -> that requester ready; both valid -> the requester not granted most recently is ready; clear=1 -> both readies 0.
REQ-011 A last_grant flag SHALL update on each completed handshake; its reset value SHALL select A as winner of the first contention.
REQ-012 rf_we, rf_waddr, rf_wdata SHALL be registered: an accepted write appears on the port exactly one cycle after the handshake, for one cycle.
REQ-013 With ZERO_R0=1, an accepted write to address 0 SHALL complete the handshake but leave rf_we=0 the following cycle; INIT zeroing of address 0 is still issued.
REQ-014 In cycles with no handshake and not in INIT, rf_we SHALL be 0; rf_waddr/rf_wdata SHALL hold their last values.
REQ-015 clear=1 in RUN SHALL move to INIT with counter 0 on the next edge; clear=1 in INIT SHALL restart the counter at 0; a write accepted in the cycle before clear is still issued.
REQ-016 Requesters SHALL hold addr/data stable while valid and not ready; the block does not buffer unaccepted writes.

Reset
REQ-017 On rst_n=0, asynchronously: state=INIT, counter=0, last_grant=B, rf_we=0, rf_waddr=0, rf_wdata=0, init_busy=1.
REQ-018 Reset asserted mid-INIT or mid-RUN SHALL discard any pending registered write; after release INIT runs in full.

Structure
REQ-019 The state encoding (INIT, RUN) and default DATA_W/ADDR_W constants SHALL live in the shared processor package.
REQ-020 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs two valids and last_grant, outputs one-hot grant).

Verification
REQ-021 Reset release, no requests -> 32 cycles with rf_we=1, rf_waddr 0..31, rf_wdata=0, init_busy=1; then init_busy=0, rf_we=0.
REQ-022 RUN, a_valid only, addr=5, data=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-023 RUN, A and B valid for 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; rf_waddr sequence 1,2,1,2 one cycle delayed.
REQ-024 RUN, b_valid addr=0 data=0x1234 with ZERO_R0=1 -> b_ready=1; rf_we stays 0 next cycle.
REQ-025 clear pulsed with a_valid held high -> a_ready=0 during clear and 32 INIT cycles; A accepted on first RUN cycle.
REQ-026 rst_n asserted at INIT count 10 -> outputs reset immediately; after release zeroing restarts at address 0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and encodings for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       i_a_valid,
    input  logic       i_b_valid,
    input  grant_t     i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_a_valid && i_b_valid) begin
            o_grant = (i_last_grant == GNT_B) ? 2'b01 : 2'b10;
        end else if (i_a_valid) begin
            o_grant = 2'b01;
        end else if (i_b_valid) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single register-file write port: zeroing sequencer after reset/clear,
// then round-robin arbitration between writeback (A) and load return (B).
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_busy
);

    state_t              r_state;
    grant_t              r_last_grant;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;

    logic [1:0]          w_grant;
    logic                w_init;
    logic                w_hs_a;
    logic                w_hs_b;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_drop;

    rr_arbiter2 u_rr_arbiter2 (
        .i_a_valid    (a_valid),
        .i_b_valid    (b_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_init    = (r_state == ST_INIT);
    assign init_busy = w_init;
    assign a_ready   = !w_init && !clear && w_grant[0];
    assign b_ready   = !w_init && !clear && w_grant[1];
    assign w_hs_a    = a_valid && a_ready;
    assign w_hs_b    = b_valid && b_ready;
    assign w_addr    = w_hs_b ? b_addr : a_addr;
    assign w_data    = w_hs_b ? b_data : a_data;
    assign w_drop    = (ZERO_R0 != 0) && (w_addr == '0);

    // Zeroing writes are decoded from the registered counter so each INIT cycle
    // carries its own address; rst_n gates the enable so reset shows rf_we=0.
    assign rf_we    = w_init ? rst_n : r_we;
    assign rf_waddr = w_init ? r_cnt : r_waddr;
    assign rf_wdata = w_init ? '0    : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_last_grant <= GNT_B;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_we <= 1'b0;
            if (clear) begin
                r_state <= ST_INIT;
                r_cnt   <= '0;
            end else if (r_state == ST_INIT) begin
                r_waddr <= r_cnt;
                r_wdata <= '0;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    r_state <= ST_RUN;
                end
            end else if (w_hs_a || w_hs_b) begin
                r_last_grant <= w_hs_b ? GNT_B : GNT_A;
                if (!w_drop) begin
                    r_we    <= 1'b1;
                    r_waddr <= w_addr;
                    r_wdata <= w_data;
                end
            end
        end
    end

endmodule
